// File: rtl/start_hs_pkg.sv
// Shared types and constants for the start/done handshake initiator.
package start_hs_pkg;

    // Handshake controller states; s is asserted only in REQ.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Default parameter values for the top level.
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;
    localparam int DEF_CNT_W           = 8;

    // Number of flops the raw key passes through before the debouncer.
    localparam int SYNC_STAGES = 2;

    // Width of a counter that must hold the values 0 .. count-1.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/start_handshake_ctrl_debouncer.sv
// Key conditioner: synchronizes the raw active-low button, filters bounce
// and emits a single-cycle pulse on each accepted press.
module key_debouncer
    import start_hs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int               RUN_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [RUN_W-1:0]       run_reg;
    logic                   level_reg;      // debounced level, 1 = pressed
    logic                   press_evt_reg;

    logic sample_pressed;
    logic differs;
    logic accept;

    // The debouncer only ever looks at the last synchronizer stage.
    assign sample_pressed = ~sync_reg[SYNC_STAGES-1];
    assign differs        = (sample_pressed != level_reg);
    // The sample that completes a full run of differing samples flips the level.
    assign accept         = differs && (run_reg == RUN_LAST);

    // Synchronizer chain; resets to the released level so no false press follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_n};
        end
    end

    // Run counter of consecutive differing samples, debounced level and press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg       <= '0;
            level_reg     <= 1'b0;
            press_evt_reg <= 1'b0;
        end else begin
            // Only the released->pressed flip produces an event.
            press_evt_reg <= accept && sample_pressed;
            if (!differs) begin
                run_reg <= '0;
            end else if (accept) begin
                run_reg   <= '0;
                level_reg <= sample_pressed;
            end else begin
                run_reg <= run_reg + RUN_W'(1);
            end
        end
    end

    assign press_evt = press_evt_reg;

endmodule

// File: rtl/start_handshake_ctrl.sv
// Upstream initiator of the four-phase start/done handshake: one request per
// debounced key press, a one-deep pending latch, a REQ/HOLD watchdog and
// status counters for the board display.
module start_handshake_ctrl
    import start_hs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic             done,
    output logic             s,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int                TCNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic press_evt;

    state_t            state_reg, state_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic              pending_reg, pending_next;
    logic [CNT_W-1:0]  done_cnt_reg;
    logic [CNT_W-1:0]  drop_cnt_reg;
    logic              s_reg, busy_reg, err_reg;

    logic done_inc;
    logic drop_inc;
    logic timeout;
    logic in_wait;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .press_evt (press_evt)
    );

    // tcnt only advances in REQ/HOLD, so the last allowed cycle there is the timeout point.
    assign timeout = (tcnt_reg == TCNT_LAST);
    assign in_wait = (state_reg == REQ) || (state_reg == HOLD);

    // Next-state, pending latch and counter-increment decisions.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        done_inc     = 1'b0;
        drop_inc     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (press_evt || pending_reg) begin
                    state_next   = REQ;
                    pending_next = 1'b0;
                end
            end
            REQ: begin
                // Acknowledge wins over a timeout in the same cycle.
                if (done) begin
                    state_next = HOLD;
                    done_inc   = 1'b1;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            HOLD: begin
                if (!done) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                // A press while downstream still shows done is ignored entirely.
                if (press_evt && !done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Presses arriving mid-handshake are remembered once, then counted as dropped.
        if (press_evt && in_wait) begin
            if (!pending_reg) begin
                pending_next = 1'b1;
            end else begin
                drop_inc = 1'b1;
            end
        end

        // A watchdog trip discards any remembered press.
        if ((state_next == ERR) && (state_reg != ERR)) begin
            pending_next = 1'b0;
        end
    end

    // Watchdog counter restarts on every entry to REQ or HOLD and idles at zero elsewhere.
    always_comb begin
        tcnt_next = '0;
        if ((state_next == state_reg) && in_wait) begin
            tcnt_next = tcnt_reg + TCNT_W'(1);
        end
    end

    // State register; outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tcnt_reg    <= '0;
            pending_reg <= 1'b0;
            s_reg       <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tcnt_reg    <= tcnt_next;
            pending_reg <= pending_next;
            s_reg       <= (state_next == REQ);
            busy_reg    <= (state_next != IDLE);
            err_reg     <= (state_next == ERR);
        end
    end

    // Status counters: completed handshakes wrap, dropped presses saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (done_inc) begin
                done_cnt_reg <= done_cnt_reg + CNT_W'(1);
            end
            if (drop_inc && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign s        = s_reg;
    assign busy     = busy_reg;
    assign err      = err_reg;
    assign done_cnt = done_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_start_handshake_ctrl.sv
// Bench for start_handshake_ctrl: scenario tasks with directed checks, plus a
// cycle-by-cycle comparison against a behavioural model of the key/handshake rules.
module tb_start_handshake_ctrl;

    localparam int DB = 4;
    localparam int TO = 20;
    localparam int CW = 8;
    localparam int OW = 2 * CW + 3;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_HOLD = 2;
    localparam int P_ERR  = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_n = 1'b1;
    logic          done  = 1'b0;
    logic          s, busy, err;
    logic [CW-1:0] done_cnt, drop_cnt;

    start_handshake_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .done     (done),
        .s        (s),
        .busy     (busy),
        .err      (err),
        .done_cnt (done_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // ---------------- behavioural reference model ----------------
    bit m_sync_q[$];     // raw key samples still travelling through the synchronizer
    bit m_win[$];        // most recent DB synchronized samples (1 = pressed)
    bit m_pressed;       // accepted key level
    bit m_press;         // press event visible to the controller this cycle
    int m_phase;
    int m_age;           // cycles spent in the current phase
    bit m_pending;
    int m_done_total;    // unbounded tallies; display rules applied on output
    int m_drop_total;

    // Lockstep bookkeeping, inspected by each scenario.
    int            lock_miss;
    logic [OW-1:0] first_got, first_want;
    time           first_t;

    // Downstream responder and random key driver.
    bit resp_on, rand_dly, rand_key;
    int rise_dly, fall_dly, s_hi, s_lo, seg_left;
    int s_rises;
    logic prev_s;

    task automatic model_reset();
        m_sync_q = '{1'b1, 1'b1};
        m_win.delete();
        m_pressed    = 1'b0;
        m_press      = 1'b0;
        m_phase      = P_IDLE;
        m_age        = 0;
        m_pending    = 1'b0;
        m_done_total = 0;
        m_drop_total = 0;
    endtask

    task automatic model_edge();
        bit synced_n, flip, new_press;
        int nphase;
        synced_n = m_sync_q.pop_front();
        m_sync_q.push_back(key_n);
        m_win.push_back(!synced_n);
        if (m_win.size() > DB) void'(m_win.pop_front());
        flip = (m_win.size() == DB);
        foreach (m_win[i]) if (m_win[i] == m_pressed) flip = 1'b0;
        new_press = flip && !m_pressed;

        nphase = m_phase;
        if (m_phase == P_IDLE) begin
            if (m_press || m_pending) begin
                nphase = P_REQ;
                m_pending = 1'b0;
            end
        end else if (m_phase == P_REQ) begin
            if (done) begin
                nphase = P_HOLD;
                m_done_total++;
            end else if (m_age == TO - 1) nphase = P_ERR;
        end else if (m_phase == P_HOLD) begin
            if (!done) nphase = P_IDLE;
            else if (m_age == TO - 1) nphase = P_ERR;
        end else begin
            if (m_press && !done) nphase = P_IDLE;
        end
        if (m_press && (m_phase == P_REQ || m_phase == P_HOLD)) begin
            if (!m_pending) m_pending = 1'b1;
            else m_drop_total++;
        end
        if (nphase == P_ERR && m_phase != P_ERR) m_pending = 1'b0;
        m_age     = (nphase == m_phase) ? m_age + 1 : 0;
        m_phase   = nphase;
        m_pressed = m_pressed ^ flip;
        m_press   = new_press;
    endtask

    function automatic logic [OW-1:0] model_outputs();
        int dc, dr;
        dc = m_done_total % (1 << CW);
        dr = (m_drop_total > (1 << CW) - 1) ? (1 << CW) - 1 : m_drop_total;
        return {m_phase == P_REQ, m_phase != P_IDLE, m_phase == P_ERR, CW'(dc), CW'(dr)};
    endfunction

    // One clock: DUT and model advance on the same edge, outputs sampled 1ns later.
    task automatic step();
        logic [OW-1:0] got, want;
        @(posedge clk);
        model_edge();
        #1;
        got  = {s, busy, err, done_cnt, drop_cnt};
        want = model_outputs();
        if (got !== want) begin
            if (lock_miss == 0) begin
                first_got  = got;
                first_want = want;
                first_t    = $time;
            end
            lock_miss++;
        end
        if (s === 1'b1 && prev_s === 1'b0) s_rises++;
        prev_s = s;
        if (resp_on) begin
            if (m_phase == P_REQ) begin
                if (s_hi == 0 && rand_dly) rise_dly = $urandom_range(1, 24);
                s_hi++;
                s_lo = 0;
                if (s_hi >= rise_dly) done = 1'b1;
            end else begin
                if (s_lo == 0 && rand_dly) fall_dly = $urandom_range(1, 24);
                s_lo++;
                s_hi = 0;
                if (s_lo >= fall_dly) done = 1'b0;
            end
        end
        if (rand_key) begin
            if (seg_left == 0) begin
                key_n    = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(1, 10);
            end
            seg_left--;
        end
    endtask

    task automatic key_for(input logic lvl, input int cycles);
        key_n = lvl;
        repeat (cycles) step();
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic apply_reset();
        key_n    = 1'b1;
        done     = 1'b0;
        resp_on  = 1'b0;
        rand_dly = 1'b0;
        rand_key = 1'b0;
        rise_dly = 3;
        fall_dly = 2;
        s_hi     = 0;
        s_lo     = 0;
        seg_left = 0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        lock_miss = 0;
        s_rises   = 0;
        prev_s    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({s, busy, err} !== 3'b000) $display("FAIL reset_flags: got s/busy/err=%b required 000", {s, busy, err});
        else passes++;
        checks++;
        if ({done_cnt, drop_cnt} !== '0) $display("FAIL reset_counters: got done_cnt=%h drop_cnt=%h required 00/00", done_cnt, drop_cnt);
        else passes++;
        repeat (10) step();
        checks++;
        if (lock_miss !== 0) $display("FAIL reset lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] reset: idle outputs observed", $time);
    endtask

    task automatic test_clean_press();
        int width;
        bit ok;
        apply_reset();
        resp_on = 1'b1;
        key_n   = 1'b0;
        repeat (6) step();
        checks++;
        if (s !== 1'b0) $display("FAIL clean_s_early: got s=%b required 0 before press event", s);
        else passes++;
        step();
        checks++;
        if (s !== 1'b1) $display("FAIL clean_s_rise: got s=%b required 1 one edge after press event", s);
        else passes++;
        width = 0;
        for (int i = 0; i < 50 && s === 1'b1; i++) begin
            width++;
            step();
        end
        checks++;
        if (width !== 3) $display("FAIL clean_s_width: got %0d cycles required 3", width);
        else passes++;
        key_n = 1'b1;
        wait_idle(40, ok);
        repeat (20) step();
        checks++;
        if (!ok || busy !== 1'b0 || done_cnt !== 8'd1 || s_rises !== 1)
            $display("FAIL clean_result: got ok=%0d busy=%b done_cnt=%0d s_rises=%0d required 1/0/1/1", ok, busy, done_cnt, s_rises);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL clean lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] clean_press: done_cnt=%0d", $time, done_cnt);
    endtask

    task automatic test_bounce();
        bit ok;
        apply_reset();
        resp_on = 1'b1;
        for (int i = 0; i < 15; i++) key_for((i % 2) == 1, 2);
        key_for(1'b0, 10);
        key_n = 1'b1;
        wait_idle(40, ok);
        repeat (20) step();
        checks++;
        if (!ok || s_rises !== 1 || done_cnt !== 8'd1)
            $display("FAIL bounce_single: got ok=%0d s_rises=%0d done_cnt=%0d required 1/1/1", ok, s_rises, done_cnt);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL bounce lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] bounce: handshakes=%0d", $time, s_rises);
    endtask

    task automatic test_double_press();
        bit ok;
        apply_reset();
        resp_on  = 1'b1;
        rise_dly = 15;
        fall_dly = 15;
        for (int i = 0; i < 3; i++) begin
            key_for(1'b0, 6);
            key_for(1'b1, 6);
        end
        checks++;
        if (drop_cnt !== 8'd1 || s !== 1'b0 || busy !== 1'b1)
            $display("FAIL double_drop: got drop_cnt=%0d s=%b busy=%b required 1/0/1", drop_cnt, s, busy);
        else passes++;
        step();
        checks++;
        if (busy !== 1'b0 || s !== 1'b0) $display("FAIL double_idle_gap: got busy=%b s=%b required 0/0", busy, s);
        else passes++;
        step();
        checks++;
        if (s !== 1'b1) $display("FAIL double_reassert: got s=%b required 1", s);
        else passes++;
        wait_idle(100, ok);
        checks++;
        if (!ok || done_cnt !== 8'd2 || drop_cnt !== 8'd1)
            $display("FAIL double_result: got ok=%0d done_cnt=%0d drop_cnt=%0d required 1/2/1", ok, done_cnt, drop_cnt);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL double lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] double_press: done_cnt=%0d drop_cnt=%0d", $time, done_cnt, drop_cnt);
    endtask

    task automatic test_timeout();
        int width;
        bit ok;
        apply_reset();
        key_for(1'b0, 7);
        key_n = 1'b1;
        width = 0;
        for (int i = 0; i < 60 && s === 1'b1; i++) begin
            width++;
            step();
        end
        checks++;
        if (width !== TO || err !== 1'b1 || s !== 1'b0 || busy !== 1'b1)
            $display("FAIL timeout_trip: got width=%0d err=%b s=%b busy=%b required %0d/1/0/1", width, err, s, busy, TO);
        else passes++;
        done = 1'b1;
        key_for(1'b0, 8);
        key_for(1'b1, 8);
        done = 1'b0;
        repeat (3) step();
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) $display("FAIL timeout_ignore_press: got err=%b busy=%b required 1/1", err, busy);
        else passes++;
        key_for(1'b0, 7);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || s !== 1'b0)
            $display("FAIL timeout_clear: got err=%b busy=%b s=%b required 0/0/0", err, busy, s);
        else passes++;
        key_for(1'b1, 8);
        resp_on = 1'b1;
        key_for(1'b0, 7);
        checks++;
        if (s !== 1'b1) $display("FAIL timeout_recover_s: got s=%b required 1", s);
        else passes++;
        key_n = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || done_cnt !== 8'd1 || drop_cnt !== 8'd0)
            $display("FAIL timeout_recover: got ok=%0d done_cnt=%0d drop_cnt=%0d required 1/1/0", ok, done_cnt, drop_cnt);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL timeout lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] timeout: trip after %0d cycles, recovered", $time, width);
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        resp_on = 1'b1;
        for (int i = 0; i < 256; i++) begin
            key_for(1'b0, $urandom_range(4, 8));
            key_for(1'b1, $urandom_range(10, 14));
            if (i == 254) begin
                wait_idle(40, ok);
                checks++;
                if (!ok || done_cnt !== 8'hFF) $display("FAIL wrap_255: got ok=%0d done_cnt=%h required 1/ff", ok, done_cnt);
                else passes++;
            end
        end
        wait_idle(40, ok);
        checks++;
        if (!ok || done_cnt !== 8'h00) $display("FAIL wrap_256: got ok=%0d done_cnt=%h required 1/00", ok, done_cnt);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL wrap lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] wrap: 256 handshakes, done_cnt=%h", $time, done_cnt);
    endtask

    task automatic test_drop_sat();
        int iter;
        apply_reset();
        resp_on  = 1'b1;
        rise_dly = 17;
        fall_dly = 17;
        iter = 0;
        while (m_drop_total < 300 && iter < 3000) begin
            key_for(1'b0, $urandom_range(4, 6));
            key_for(1'b1, $urandom_range(4, 6));
            iter++;
        end
        checks++;
        if (m_drop_total < 300 || drop_cnt !== 8'hFF)
            $display("FAIL drop_saturate: got drop_cnt=%h after %0d drops required ff after >=300", drop_cnt, m_drop_total);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL drop lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] drop_sat: %0d dropped presses, drop_cnt=%h", $time, m_drop_total, drop_cnt);
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        resp_on = 1'b1;
        key_for(1'b0, 8);
        key_for(1'b1, 10);
        wait_idle(40, ok);
        resp_on = 1'b0;
        done    = 1'b0;
        key_for(1'b0, 9);
        checks++;
        if (!ok || s !== 1'b1 || done_cnt !== 8'd1)
            $display("FAIL areset_pre: got ok=%0d s=%b done_cnt=%0d required 1/1/1", ok, s, done_cnt);
        else passes++;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({s, busy, err} !== 3'b000 || done_cnt !== 8'd0 || drop_cnt !== 8'd0)
            $display("FAIL areset_async: got s/busy/err=%b done_cnt=%0d drop_cnt=%0d required 000/0/0", {s, busy, err}, done_cnt, drop_cnt);
        else passes++;
        model_reset();
        key_n = 1'b1;
        #2 rst_n = 1'b1;
        resp_on = 1'b1;
        s_hi = 0;
        s_lo = 0;
        key_for(1'b1, 4);
        key_for(1'b0, 7);
        checks++;
        if (s !== 1'b1) $display("FAIL areset_press: got s=%b required 1", s);
        else passes++;
        key_n = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || done_cnt !== 8'd1) $display("FAIL areset_after: got ok=%0d done_cnt=%0d required 1/1", ok, done_cnt);
        else passes++;
        checks++;
        if (lock_miss !== 0) $display("FAIL areset lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] async_reset: cleared mid-request, recovered done_cnt=%0d", $time, done_cnt);
    endtask

    task automatic test_random();
        apply_reset();
        resp_on  = 1'b1;
        rand_dly = 1'b1;
        rand_key = 1'b1;
        repeat (4000) step();
        checks++;
        if (lock_miss !== 0) $display("FAIL random lockstep: %0d mismatches, first @%0t got %h required %h", lock_miss, first_t, first_got, first_want);
        else passes++;
        $display("[%0t] random: handshakes=%0d drops=%0d", $time, m_done_total, m_drop_total);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_double_press();
        test_timeout();
        test_wrap();
        test_drop_sat();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
